// File: rtl/ddr_pkg.sv
// ddr_pkg: shared defaults and beat/tag types for the DDR read-return path
package ddr_pkg;
  localparam int DEF_TAG_W = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BURST_LEN = 8;
  localparam int DEF_MAX_OUTSTANDING = 8;
  localparam int DEF_DATA_DEPTH = 16;
  typedef logic [DEF_TAG_W-1:0] rd_tag_t;
  typedef logic [DEF_DATA_W-1:0] beat_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head, occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  always_comb begin
    data_o = mem_q[rd_q];
    full_o = count_q == CW'(DEPTH);
    empty_o = count_q == '0;
    count_o = count_q;
  end
  // DEPTH is a power of two, so pointers wrap exactly at their width
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/rd_return_tracker.sv
// rd_return_tracker: pairs issued read tags with returned PHY beats and streams
// them out as tagged bursts, retiring each tag on its last beat.
module rd_return_tracker
  import ddr_pkg::*;
#(
  parameter int TAG_W = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic                                 cmd_valid,
  input  logic [TAG_W-1:0]                     cmd_tag,
  output logic                                 cmd_ready,
  input  logic                                 beat_valid,
  input  logic [DATA_W-1:0]                    beat_data,
  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic [DATA_W-1:0]                    resp_data,
  output logic [TAG_W-1:0]                     resp_tag,
  output logic                                 resp_last,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 err_unexpected,
  output logic                                 err_overflow
);
  localparam int BW = $clog2(BURST_LEN);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  logic tag_full, tag_empty, data_full, data_empty;
  logic cmd_acc, beat_take, beat_push, burst_done, resp_fire, tag_pop;
  logic [BW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [OW-1:0] pending_q, pending_d;
  logic err_unexp_q, err_ovf_q;
  logic [$clog2(DATA_DEPTH+1)-1:0] data_cnt_unused;
  always_comb begin
    cmd_ready = !tag_full;
    cmd_acc = cmd_valid && !tag_full;
    beat_take = beat_valid && pending_q != '0;
    beat_push = beat_take && !data_full;
    burst_done = beat_take && in_cnt_q == BW'(BURST_LEN-1);
    in_cnt_d = !beat_take ? in_cnt_q : burst_done ? '0 : in_cnt_q + BW'(1);
    pending_d = pending_q + OW'(cmd_acc) - OW'(burst_done);
    resp_valid = !data_empty && !tag_empty;
    resp_last = resp_valid && out_cnt_q == BW'(BURST_LEN-1);
    resp_fire = resp_valid && resp_ready;
    tag_pop = resp_fire && resp_last;
    out_cnt_d = !resp_fire ? out_cnt_q : resp_last ? '0 : out_cnt_q + BW'(1);
    err_unexpected = err_unexp_q;
    err_overflow = err_ovf_q;
  end
  // a dropped overflow beat still advances in_cnt so later bursts stay aligned
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      in_cnt_q <= '0;
      out_cnt_q <= '0;
      pending_q <= '0;
      err_unexp_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      in_cnt_q <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      pending_q <= pending_d;
      err_unexp_q <= beat_valid && pending_q == '0;
      err_ovf_q <= err_ovf_q || (beat_take && data_full);
    end
  end
  sync_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk(clk), .n_rst(n_rst), .push_i(cmd_acc), .pop_i(tag_pop), .data_i(cmd_tag),
    .data_o(resp_tag), .full_o(tag_full), .empty_o(tag_empty), .count_o(outstanding)
  );
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH)) u_beat_fifo (
    .clk(clk), .n_rst(n_rst), .push_i(beat_push), .pop_i(resp_fire), .data_i(beat_data),
    .data_o(resp_data), .full_o(data_full), .empty_o(data_empty), .count_o(data_cnt_unused)
  );
endmodule

// File: tb/tb_rd_return_tracker.sv
// tb_rd_return_tracker: directed and random stimulus checked every cycle
// against a queue-based transaction model of the read-return tracker
module tb_rd_return_tracker;
  localparam int BL = 8;
  localparam int MAXO = 8;
  localparam int DD = 16;
  logic clk = 0, n_rst = 0;
  logic cmd_valid = 0, cmd_ready, beat_valid = 0, resp_valid, resp_ready = 0, resp_last;
  logic [3:0] cmd_tag = 0, resp_tag;
  logic [31:0] beat_data = 0, resp_data;
  logic [3:0] outstanding;
  logic err_unexpected, err_overflow;
  int n_chk = 0, n_fail = 0;
  logic [3:0] tq[$];
  logic [31:0] bq[$];
  int pend, in_c, out_c;
  bit m_unexp, m_ovf;

  rd_return_tracker dut (
    .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid), .cmd_tag(cmd_tag), .cmd_ready(cmd_ready),
    .beat_valid(beat_valid), .beat_data(beat_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag), .resp_last(resp_last),
    .outstanding(outstanding), .err_unexpected(err_unexpected), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    tq.delete();
    bq.delete();
    pend = 0;
    in_c = 0;
    out_c = 0;
    m_unexp = 0;
    m_ovf = 0;
  endtask

  task automatic check_outputs();
    bit rv;
    rv = bq.size() > 0 && tq.size() > 0;
    chk("cmd_ready", cmd_ready, tq.size() < MAXO);
    chk("outstanding", outstanding, tq.size());
    chk("resp_valid", resp_valid, rv);
    chk("resp_last", resp_last, rv && out_c == BL - 1);
    chk("err_unexpected", err_unexpected, m_unexp);
    chk("err_overflow", err_overflow, m_ovf);
    if (rv) begin
      chk("resp_data", resp_data, bq[0]);
      chk("resp_tag", resp_tag, tq[0]);
    end
  endtask

  task automatic model_update(input bit cv, input logic [3:0] t, input bit bv,
                              input logic [31:0] d, input bit rr);
    bit ca, fire, take, full, lastf;
    ca = cv && tq.size() < MAXO;
    fire = bq.size() > 0 && tq.size() > 0 && rr;
    take = bv && pend > 0;
    full = bq.size() >= DD;
    lastf = fire && out_c == BL - 1;
    m_unexp = bv && pend == 0;
    if (fire) begin
      void'(bq.pop_front());
      if (lastf) void'(tq.pop_front());
      out_c = lastf ? 0 : out_c + 1;
    end
    if (take) begin
      if (!full) bq.push_back(d);
      else m_ovf = 1;
      if (in_c == BL - 1) begin
        in_c = 0;
        pend--;
      end else in_c++;
    end
    if (ca) begin
      tq.push_back(t);
      pend++;
    end
  endtask

  task automatic step(input bit cv, input logic [3:0] t, input bit bv,
                      input logic [31:0] d, input bit rr);
    cmd_valid = cv;
    cmd_tag = t;
    beat_valid = bv;
    beat_data = d;
    resp_ready = rr;
    @(negedge clk);
    check_outputs();
    model_update(cv, t, bv, d, rr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 0;
    cmd_valid = 0;
    beat_valid = 0;
    resp_ready = 0;
    model_clear();
    #2;
    check_outputs();
    @(negedge clk);
    n_rst = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    do_reset();
    // single read
    step(1, 4'h5, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'h10 + i, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    chk("single_outstanding", outstanding, 0);
    // reset after 3 of 8 beats
    step(1, 4'h9, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h100 + i, 0);
    do_reset();
    step(0, 0, 0, 0, 0);
    // back-pressure and ordering
    for (int i = 1; i <= 3; i++) step(1, 4'(i), 0, 0, 0);
    for (int i = 0; i < 24; i++) step(0, 0, 1, 32'h200 + i, i % 2 == 0);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 0, i % 2 == 1);
    chk("bp_drained", outstanding, 0);
    // full tag FIFO, 9th command refused
    for (int i = 0; i < 9; i++) step(1, 4'(i), 0, 0, 0);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_outstanding", outstanding, 8);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'h300 + i, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    chk("full_ready_again", cmd_ready, 1);
    do_reset();
    // command accepted on the same edge as resp_last
    step(1, 4'hA, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'h400 + i, 0);
    repeat (7) step(0, 0, 0, 0, 1);
    chk("pre_last", resp_last, 1);
    step(1, 4'hB, 0, 0, 1);
    chk("simul_outstanding", outstanding, 1);
    chk("simul_tag", resp_tag, 4'hB);
    do_reset();
    // unexpected beat
    step(0, 0, 1, 32'hdead, 1);
    chk("unexp_pulse", err_unexpected, 1);
    chk("unexp_no_resp", resp_valid, 0);
    step(0, 0, 0, 0, 1);
    chk("unexp_cleared", err_unexpected, 0);
    // overflow: 17 beats into a 16-deep buffer
    for (int i = 0; i < 3; i++) step(1, 4'(i + 4), 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 32'h500 + i, 0);
    chk("ovf_set", err_overflow, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 32'h600 + i, 1);
    repeat (20) step(0, 0, 0, 0, 1);
    chk("ovf_sticky", err_overflow, 1);
    do_reset();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 3) == 0, 4'($urandom), pend > 0 ? $urandom_range(0, 3) != 0
           : $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rd_return_tracker.md
Name: rd_return_tracker

Overview:
- Read-side completion partner to the transaction counter.
- The issue path counts read commands out; this block accepts the tag of each issued read and collects the read-data beats the PHY returns, BURST_LEN beats per read, in order.
- It presents the beats on a valid/ready response stream tagged with the matching command's tag, and retires the tag on the last beat.
- Sits between the PHY read-capture path and the host read-response port.

Parameters:
TAG_W, 4, width of read command tag
DATA_W, 32, width of one data beat
BURST_LEN, 8, beats per read burst (power of 2, >=2)
MAX_OUTSTANDING, 8, tag FIFO depth (power of 2)
DATA_DEPTH, 16, beat buffer depth (power of 2, >= BURST_LEN)

Ports:
clk  in  1  system clock, all logic on rising edge
n_rst  in  1  asynchronous active-low reset
cmd_valid  in  1  read command issued, tag valid
cmd_tag  in  TAG_W  tag of issued read
cmd_ready  out  1  tag FIFO not full
beat_valid  in  1  PHY read beat present; cannot be stalled
beat_data  in  DATA_W  PHY read beat
resp_valid  out  1  response beat available
resp_ready  in  1  host accepts response beat
resp_data  out  DATA_W  response beat
resp_tag  out  TAG_W  tag of burst being returned
resp_last  out  1  final beat of burst
outstanding  out  $clog2(MAX_OUTSTANDING+1)  tags accepted but not yet retired
err_unexpected  out  1  one-cycle pulse: beat dropped, no read pending
err_overflow  out  1  sticky: beat dropped because beat buffer was full

Behaviour:
- Reset (async, n_rst=0): both FIFOs empty; all counters 0; cmd_ready=1; resp_valid=0; resp_last=0; outstanding=0; err_unexpected=0; err_overflow=0. The reset state holds until the first clk edge after deassertion. Reset mid-burst discards all state.
- Command accept: cmd_valid&&cmd_ready pushes cmd_tag into the tag FIFO and increments pending_bursts and outstanding. cmd_ready=!tag_full is combinational from registered state.
- Beat accept:
  - When beat_valid and pending_bursts>0 and the beat buffer is not full, beat_data is pushed.
  - in_beat_cnt increments; on reaching BURST_LEN-1 it wraps to 0 and pending_bursts decrements.
  - A command accept in the same cycle as a burst completion leaves pending_bursts unchanged.
- Drop rules:
  - beat_valid with pending_bursts==0: beat dropped, counters unchanged, err_unexpected=1 for the next cycle only.
  - beat_valid with pending_bursts>0 and beat buffer full: beat dropped, err_overflow set and held until reset. in_beat_cnt still advances, to keep burst alignment.
- Response:
  - resp_valid=!data_empty && !tag_empty.
  - resp_data is the beat FIFO head; resp_tag is the tag FIFO head.
  - resp_last=resp_valid && (out_beat_cnt==BURST_LEN-1).
  - On resp_valid&&resp_ready, the beat is popped and out_beat_cnt increments, wrapping at BURST_LEN.
  - If resp_last, the tag is popped and outstanding decrements.
  - resp_* hold stable while resp_valid&&!resp_ready.
- Simultaneous command accept and tag retire: outstanding unchanged; both FIFO push and pop occur.
- Latency: a beat accepted at edge N is visible on resp_data after edge N (zero extra stages), provided the buffer was empty and a tag is present.
- Widths: all counters use exact $clog2 widths; wrap is explicit compare-and-clear, never relying on natural overflow unless the width matches exactly.
- Invariant: outstanding == tag FIFO occupancy; pending_bursts <= outstanding.

Decomposition:
- ddr_pkg: TAG_W, BURST_LEN defaults; typedef rd_tag_t; typedef beat_t.
- One reusable sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated twice: tag FIFO and beat buffer.
- Counters and error logic stay in rd_return_tracker.

Test Plan:
- Reset: assert n_rst=0 mid-burst after 3 of 8 beats, then release -> outstanding=0, resp_valid=0, cmd_ready=1, err_overflow=0 on the first edge after release.
- Single read: cmd_tag=4'h5, then 8 beats 0x10..0x17 back-to-back with resp_ready=1 -> 8 responses with tag 5 and data 0x10..0x17, resp_last only on 0x17, outstanding 1->0.
- Back-pressure and ordering: tags 1,2,3 issued; 24 beats returned; resp_ready toggled 1/0 -> responses in order, tags 1,2,3 each with exactly 8 beats, data stable while stalled.
- Full tag FIFO: issue 8 tags without returns -> cmd_ready=0 and outstanding=8. A 9th cmd_valid is not accepted. Returning one full burst -> cmd_ready=1 after its resp_last handshake.
- Simultaneous accept and retire: cmd accepted on the same edge as the resp_last handshake -> outstanding unchanged.
- Errors:
  - beat_valid with no command pending -> err_unexpected pulses one cycle, no response produced.
  - resp_ready=0 with 3 tags issued and 17 beats sent -> err_overflow=1 and stays set.
